// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: producer side pushes operands,
// consumer side pops results with flags.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Alu_out;
  logic             overflow;
  logic             zero;
  logic             neg;
  logic             carry;

  modport master (
    output in_valid, opcode, A, B, out_ready,
    input  in_ready, out_valid, Alu_out, overflow, zero, neg, carry
  );

  modport slave (
    input  in_valid, opcode, A, B, out_ready,
    output in_ready, out_valid, Alu_out, overflow, zero, neg, carry
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake: single-cycle ops load the output
// register at acceptance; MUL runs a WIDTH-cycle shift-add before loading it.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_XOR  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic {IDLE, MUL} state_e;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               ovf_q, ovf_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  logic [WIDTH-1:0]   a, b, alu_res, diff;
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     sum_w, shl_w, shr_w, sra_w;
  logic               alu_c, alu_v, is_mul, ready;
  logic [2*WIDTH-1:0] acc_nx;

  assign a      = bus.A;
  assign b      = bus.B;
  assign sh     = bus.B[SHW-1:0];
  assign is_mul = MUL_EN && (bus.opcode == OP_MUL);

  // Shifts run on a WIDTH+1 vector so the extra bit catches the last bit shifted out.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum_w   = {1'b0, a} + {1'b0, b};
    diff    = a - b;
    shl_w   = {1'b0, a} << sh;
    shr_w   = {a, 1'b0} >> sh;
    sra_w   = $signed({a, 1'b0}) >>> sh;
    case (bus.opcode)
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR: alu_res = a ^ b;
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOR: alu_res = ~(a | b);
      OP_SLL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SRL: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = a < b;
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SRA: begin
        alu_res = sra_w[WIDTH:1];
        alu_c   = sra_w[0];
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      default: ;
    endcase
  end

  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    ovf_d       = ovf_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ready       = 1'b0;
    case (state_q)
      IDLE: begin
        ready = !out_valid_q || bus.out_ready;
        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        if (bus.in_valid && ready) begin
          if (is_mul) begin
            state_d     = MUL;
            out_valid_d = 1'b0;
            mcand_d     = {{WIDTH{1'b0}}, a};
            mplier_d    = b;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            out_valid_d = 1'b1;
            res_d       = alu_res;
            ovf_d       = alu_v;
            carry_d     = alu_c;
            zero_d      = (alu_res == '0);
            neg_d       = alu_res[WIDTH-1];
          end
        end
      end
      MUL: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          res_d       = acc_nx[WIDTH-1:0];
          ovf_d       = |acc_nx[2*WIDTH-1:WIDTH];
          carry_d     = 1'b0;
          zero_d      = (acc_nx[WIDTH-1:0] == '0);
          neg_d       = acc_nx[WIDTH-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = ready && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.Alu_out   = res_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe: hand-computed results, backpressure,
// multiply latency and reset abort.
module tb_alu_pipe;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nmis = 0;

  alu_pipe_if #(.WIDTH(W)) bus ();
  alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic send(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.A        = a;
    bus.B        = b;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.opcode   = 4'hF;
    bus.A        = $urandom;
    bus.B        = $urandom;
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] res,
                         input logic z, input logic n, input logic c, input logic v);
    chk({tag, "_vld"}, bus.out_valid, 1'b1);
    chk({tag, "_res"}, bus.Alu_out, res);
    chk({tag, "_flags(zncv)"}, {bus.zero, bus.neg, bus.carry, bus.overflow}, {z, n, c, v});
  endtask

  task automatic op(input string tag, input logic [3:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] res, input logic z, input logic n, input logic c, input logic v);
    send(tag, opc, a, b);
    chk_out(tag, res, z, n, c, v);
  endtask

  task automatic mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] res, input logic z, input logic n, input logic v);
    int lat, busy;
    send(tag, 4'd11, a, b);
    lat  = 1;
    busy = 0;
    while (!bus.out_valid && lat < 100) begin
      if (!bus.in_ready) busy++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 33);
    chk({tag, "_busy"}, busy, 32);
    chk_out(tag, res, z, n, 1'b0, v);
    chk({tag, "_rdy_after"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.opcode    = 4'd0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {bus.out_valid, bus.in_ready, bus.zero, bus.neg, bus.carry, bus.overflow}, 6'b0);
    chk("rst_res", bus.Alu_out, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_rdy", bus.in_ready, 1'b1);

    //      tag       op     A             B             result        z     n     c     v
    op("add",      4'd0,  32'd5,        32'd10,       32'd15,       1'b0, 1'b0, 1'b0, 1'b0);
    op("nor",      4'd4,  32'd46,       32'd200,      32'hFFFFFF11, 1'b0, 1'b1, 1'b0, 1'b0);
    op("sub",      4'd7,  32'd67,       32'd55,       32'd12,       1'b0, 1'b0, 1'b0, 1'b0);
    op("sub_brw",  4'd7,  32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    op("add_ovf",  4'd0,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    op("add_cy",   4'd0,  32'hFFFFFFFF, 32'd1,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0);
    op("sub_ovf",  4'd7,  32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    op("sra",      4'd8,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b1, 1'b0, 1'b0);
    op("sra31",    4'd8,  32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    op("sll",      4'd5,  32'h80000001, 32'd1,        32'd2,        1'b0, 1'b0, 1'b1, 1'b0);
    op("sll_sh0",  4'd5,  32'h80000001, 32'd32,       32'h80000001, 1'b0, 1'b1, 1'b0, 1'b0);
    op("srl",      4'd6,  32'd3,        32'd1,        32'd1,        1'b0, 1'b0, 1'b1, 1'b0);
    op("srl31",    4'd6,  32'hC0000000, 32'd31,       32'd1,        1'b0, 1'b0, 1'b1, 1'b0);
    op("slt",      4'd9,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0, 1'b0);
    op("sltu",     4'd10, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b0, 1'b0);
    op("xor",      4'd1,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1'b0, 1'b0, 1'b0);
    op("and",      4'd2,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1'b0, 1'b0);
    op("or",       4'd3,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
    op("rsvd",     4'd13, 32'd5,        32'd3,        32'd0,        1'b1, 1'b0, 1'b0, 1'b0);

    // Drain, then hold the consumer off while two ADDs are offered.
    @(posedge clk);
    #1;
    chk("drain_vld", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;
    op("bp_first", 4'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.opcode   = 4'd0;
    bus.A        = 32'd4;
    bus.B        = 32'd5;
    #1;
    chk("bp_rdy_low", bus.in_ready, 1'b0);
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.Alu_out !== 32'd3 || bus.in_ready !== 1'b0) seen++;
    end
    chk("bp_hold", seen, 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk_out("bp_second", 32'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("bp_pop", bus.out_valid, 1'b0);

    mul("mul",     32'd7,        32'd6,        32'd42,       1'b0, 1'b0, 1'b0);
    mul("mul_hi",  32'h00010000, 32'h00010000, 32'h0,        1'b1, 1'b0, 1'b1);
    mul("mul_neg", 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b0, 1'b1, 1'b1);

    // Pop the last product, then abort a multiply with reset at cycle 10.
    @(posedge clk);
    #1;
    send("mul_abort", 4'd11, 32'd3, 32'd3);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_busy", bus.in_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_rst_rdy", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rdy", bus.in_ready, 1'b1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("abort_no_vld", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
